audio_sequencer: RTL and testbench

Playback controller for the song-ROM audio path. It sequences a selected song's note words out of the synchronous note ROMs, one word per beat, and drives the tone generator. It handles start/stop/pause, end-of-song detection and looping, and replaces the free-running timer/counter pair in front of the song ROMs and output mux.

---
 rtl/audio_pkg.sv | 23 ++
 rtl/audio_beat_timer.sv | 32 +++
 rtl/audio_sequencer.sv | 136 +++++++++++++
 tb/tb_audio_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the song-ROM playback path.
package audio_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_FETCH = 3'd2,
      ST_PLAY  = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_t;

   localparam int NOTE_W = 20;
   localparam int ADDR_W = 5;
   localparam logic [NOTE_W-1:0] END_CODE = 20'hFFFFF;

   localparam logic [2:0] SONG_MIN = 3'd1;
   localparam logic [2:0] SONG_MAX = 3'd3;

   function automatic logic song_valid(input logic [2:0] sel);
      return (sel >= SONG_MIN) && (sel <= SONG_MAX);
   endfunction

endpackage

// File: rtl/audio_beat_timer.sv
// Beat timer: counts enabled cycles and pulses tick on the last cycle of a beat.
module audio_beat_timer #(
   parameter int TICK_DIV = 12_500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] count;

   // Gating with en makes pause win over a tick landing in the same cycle.
   assign tick = en && (count == TERM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else if (en) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/audio_sequencer.sv
// Song-ROM playback controller: steps one note word per beat into the tone generator.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | stopped, note silenced, waiting for a valid start
// ST_ADDR  | ROM is registering rom_addr/rom_song
// ST_FETCH | rom_data valid: load note, loop, or finish
// ST_PLAY  | holding note for one beat (frozen and silenced while paused)
// ST_DONE  | song finished, done pulse issued on the way to idle
module audio_sequencer
   import audio_pkg::*;
#(
   parameter int TICK_DIV = 12_500_000,
   parameter int ADDR_W   = audio_pkg::ADDR_W,
   parameter int NOTE_W   = audio_pkg::NOTE_W,
   parameter logic [NOTE_W-1:0] END_CODE = audio_pkg::END_CODE,
   parameter int LOOP     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic [2:0]        song_sel,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [2:0]        rom_song,
   input  logic [NOTE_W-1:0] rom_data,
   output logic [NOTE_W-1:0] note,
   output logic              playing,
   output logic              done
);

   seq_state_t        state, state_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [2:0]        song_nxt;
   logic [NOTE_W-1:0] note_nxt;
   logic [NOTE_W-1:0] word, word_nxt;
   logic              done_nxt;
   logic              beat_clr;
   logic              beat_en;
   logic              beat_tick;

   assign beat_en = (state == ST_PLAY) && !pause;
   assign playing = (state == ST_ADDR) || (state == ST_FETCH) || (state == ST_PLAY);

   audio_beat_timer #(
      .TICK_DIV(TICK_DIV)
   ) u_beat_timer (
      .clk (clk),
      .rst (rst),
      .clr (beat_clr),
      .en  (beat_en),
      .tick(beat_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         rom_addr <= '0;
         rom_song <= '0;
         note     <= '0;
         word     <= '0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         rom_addr <= addr_nxt;
         rom_song <= song_nxt;
         note     <= note_nxt;
         word     <= word_nxt;
         done     <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      addr_nxt  = rom_addr;
      song_nxt  = rom_song;
      note_nxt  = note;
      word_nxt  = word;
      done_nxt  = 1'b0;
      beat_clr  = 1'b0;

      if (stop) begin
         state_nxt = ST_IDLE;
         addr_nxt  = '0;
         note_nxt  = '0;
      end else if (start && song_valid(song_sel)) begin
         // Restart keeps the current note sounding until the new first word arrives.
         state_nxt = ST_ADDR;
         song_nxt  = song_sel;
         addr_nxt  = '0;
         if ((state == ST_IDLE) || (state == ST_DONE)) begin
            note_nxt = '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               note_nxt = '0;
            end
            ST_ADDR: begin
               state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
               if (rom_data != END_CODE) begin
                  note_nxt  = rom_data;
                  word_nxt  = rom_data;
                  beat_clr  = 1'b1;
                  state_nxt = ST_PLAY;
               end else if ((rom_addr == '0) || (LOOP == 0)) begin
                  state_nxt = ST_DONE;
               end else begin
                  addr_nxt  = '0;
                  state_nxt = ST_ADDR;
               end
            end
            ST_PLAY: begin
               note_nxt = pause ? '0 : word;
               if (beat_tick) begin
                  addr_nxt  = rom_addr + ADDR_W'(1);
                  state_nxt = ST_ADDR;
               end
            end
            ST_DONE: begin
               note_nxt  = '0;
               done_nxt  = 1'b1;
               state_nxt = ST_IDLE;
            end
            default: begin
               state_nxt = ST_IDLE;
               note_nxt  = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_audio_sequencer.sv
// Bench for audio_sequencer: two instances (LOOP=0 / LOOP=1) against a cycle-level reference model.
module tb_audio_sequencer;

   localparam int TICK = 4;
   localparam logic [19:0] ENDW = 20'hFFFFF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, stop = 1'b0, pause = 1'b0;
   logic [2:0] song_sel = 3'd0;

   logic [4:0]  addr0, addr1;
   logic [2:0]  song0, song1;
   logic [19:0] rd0, rd1, note0, note1;
   logic        play0, play1, done0, done1;

   logic [19:0] rom [8][32];

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   audio_sequencer #(.TICK_DIV(TICK), .LOOP(0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .song_sel(song_sel),
      .rom_addr(addr0), .rom_song(song0), .rom_data(rd0), .note(note0), .playing(play0), .done(done0));

   audio_sequencer #(.TICK_DIV(TICK), .LOOP(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .song_sel(song_sel),
      .rom_addr(addr1), .rom_song(song1), .rom_data(rd1), .note(note1), .playing(play1), .done(done1));

   // Synchronous ROMs, one cycle latency
   always @(posedge clk) begin
      rd0 <= rom[song0][addr0];
      rd1 <= rom[song1][addr1];
   end

   // Reference model: tracks the song position and beat progress directly.
   typedef struct {
      bit          busy;
      bit          ending;
      bit          done;
      logic [2:0]  song;
      int          addr;
      int          lat;
      int          beat;
      logic [19:0] word;
      logic [19:0] note;
   } mdl_t;

   mdl_t md [2];

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.busy = 0; m.ending = 0; m.done = 0; m.song = 3'd0; m.addr = 0;
      m.lat = 0; m.beat = 0; m.word = '0; m.note = '0;
      return m;
   endfunction

   task automatic step_model(input int i, input bit loop);
      mdl_t c, n;
      logic [19:0] w;
      c = md[i];
      n = c;
      n.done = 1'b0;
      if (stop) begin
         n.busy = 0; n.ending = 0; n.addr = 0; n.note = '0;
      end else if (start && song_sel >= 3'd1 && song_sel <= 3'd3) begin
         n.busy = 1; n.ending = 0; n.song = song_sel; n.addr = 0; n.lat = 2;
         if (!c.busy) n.note = '0;
      end else if (c.ending) begin
         n.ending = 0; n.done = 1; n.note = '0;
      end else if (!c.busy) begin
         n.note = '0;
      end else if (c.lat == 2) begin
         n.lat = 1;
      end else if (c.lat == 1) begin
         w = rom[c.song][c.addr];
         if (w != ENDW) begin
            n.word = w; n.note = w; n.beat = 0; n.lat = 0;
         end else if (c.addr == 0 || !loop) begin
            n.busy = 0; n.ending = 1;
         end else begin
            n.addr = 0; n.lat = 2;
         end
      end else if (pause) begin
         n.note = '0;
      end else begin
         n.note = c.word;
         n.beat = c.beat + 1;
         if (n.beat == TICK) begin
            n.beat = 0;
            n.addr = (c.addr + 1) % 32;
            n.lat  = 2;
         end
      end
      md[i] = n;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         md[0] = mdl_reset();
         md[1] = mdl_reset();
      end else begin
         step_model(0, 1'b0);
         step_model(1, 1'b1);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (chk_en && !rst) begin
         chk("model0", {2'b0, note0, addr0, song0, play0, done0},
             {2'b0, md[0].note, 5'(md[0].addr), md[0].song, md[0].busy, md[0].done});
         chk("model1", {2'b0, note1, addr1, song1, play1, done1},
             {2'b0, md[1].note, 5'(md[1].addr), md[1].song, md[1].busy, md[1].done});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [2:0] s);
      start = 1'b1; song_sel = s;
      cyc();
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      cyc();
   endtask

   typedef struct {
      int          cyc;
      logic [19:0] n0;
      bit          p0;
      bit          d0;
      logic [4:0]  a0;
      logic [19:0] n1;
      logic [4:0]  a1;
      bit          d1;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int ti;
      int guard;

      tbl[0] = '{1,  20'd0,   1, 0, 5'd0, 20'd0,   5'd0, 0};
      tbl[1] = '{2,  20'd0,   1, 0, 5'd0, 20'd0,   5'd0, 0};
      tbl[2] = '{3,  20'd100, 1, 0, 5'd0, 20'd100, 5'd0, 0};
      tbl[3] = '{6,  20'd100, 1, 0, 5'd0, 20'd100, 5'd0, 0};
      tbl[4] = '{7,  20'd100, 1, 0, 5'd1, 20'd100, 5'd1, 0};
      tbl[5] = '{9,  20'd200, 1, 0, 5'd1, 20'd200, 5'd1, 0};
      tbl[6] = '{14, 20'd200, 1, 0, 5'd2, 20'd200, 5'd2, 0};
      tbl[7] = '{15, 20'd200, 0, 0, 5'd2, 20'd200, 5'd0, 0};
      tbl[8] = '{16, 20'd0,   0, 1, 5'd2, 20'd200, 5'd0, 0};
      tbl[9] = '{17, 20'd0,   0, 0, 5'd2, 20'd100, 5'd0, 0};

      for (int s = 0; s < 8; s++)
         for (int a = 0; a < 32; a++) rom[s][a] = '0;
      rom[1][0] = 20'd100; rom[1][1] = 20'd200; rom[1][2] = ENDW;
      for (int a = 0; a < 32; a++) rom[2][a] = 20'd1000 + 20'(a);
      rom[3][0] = ENDW; rom[3][1] = 20'd777;

      // Reset state
      #12;
      chk("rst0", {note0, addr0, song0, play0, done0}, 32'd0);
      chk("rst1", {note1, addr1, song1, play1, done1}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk_en = 1'b1;
      cyc(); cyc();

      // Basic play (LOOP=0) and loop (LOOP=1) against the timing table
      pulse_start(3'd1);
      ti = 0;
      for (int k = 1; k <= 17; k++) begin
         if (ti < 10 && tbl[ti].cyc == k) begin
            chk($sformatf("tbl_note0_c%0d", k), note0, tbl[ti].n0);
            chk($sformatf("tbl_play0_c%0d", k), play0, tbl[ti].p0);
            chk($sformatf("tbl_done0_c%0d", k), done0, tbl[ti].d0);
            chk($sformatf("tbl_addr0_c%0d", k), addr0, tbl[ti].a0);
            chk($sformatf("tbl_note1_c%0d", k), note1, tbl[ti].n1);
            chk($sformatf("tbl_addr1_c%0d", k), addr1, tbl[ti].a1);
            chk($sformatf("tbl_done1_c%0d", k), done1, tbl[ti].d1);
            ti++;
         end
         cyc();
      end
      for (int k = 0; k < 30; k++) begin
         chk("loop_no_done", done1, 1'b0);
         cyc();
      end
      do_stop();

      // Pause for 10 cycles in the middle of note 100
      pulse_start(3'd1);
      cyc(); cyc(); cyc();
      pause = 1'b1;
      for (int k = 4; k <= 13; k++) begin
         if (k == 5)  chk("pause_note0", note0, 20'd0);
         if (k == 10) chk("pause_addr0", addr0, 5'd0);
         cyc();
      end
      pause = 1'b0;
      cyc();
      chk("pause_resume", note0, 20'd100);
      cyc(); cyc(); cyc();
      chk("pause_fetch_hold", note0, 20'd100);
      cyc();
      chk("pause_next_note", note0, 20'd200);
      do_stop();

      // Stop during PLAY, then start+stop together
      pulse_start(3'd1);
      for (int k = 1; k < 10; k++) cyc();
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk("stop_note", note0, 20'd0);
      chk("stop_play", play0, 1'b0);
      chk("stop_addr", addr0, 5'd0);
      chk("stop_done", done0, 1'b0);
      cyc();
      chk("stop_done2", done0, 1'b0);
      start = 1'b1; stop = 1'b1; song_sel = 3'd2;
      cyc();
      start = 1'b0; stop = 1'b0;
      chk("start_stop_idle", play0, 1'b0);
      cyc();
      chk("start_stop_idle2", play1, 1'b0);

      // Invalid start in idle, then restart with a different song
      pulse_start(3'd0);
      chk("invalid_idle", play0, 1'b0);
      pulse_start(3'd5);
      chk("invalid_idle2", play0, 1'b0);
      pulse_start(3'd1);
      for (int k = 1; k < 5; k++) cyc();
      pulse_start(3'd6);
      chk("invalid_while_play", song0, 3'd1);
      pulse_start(3'd2);
      chk("restart_song", song0, 3'd2);
      chk("restart_addr", addr0, 5'd0);
      cyc(); cyc();
      chk("restart_note", note0, 20'd1000);
      do_stop();

      // Empty song reports done even when looping
      pulse_start(3'd3);
      cyc();
      chk("empty_nodone_c2", done1, 1'b0);
      cyc();
      cyc();
      chk("empty_done0", done0, 1'b1);
      chk("empty_done1", done1, 1'b1);
      chk("empty_play1", play1, 1'b0);
      cyc();
      chk("empty_done_once", done1, 1'b0);
      cyc();

      // Address wrap on a 32-word song
      pulse_start(3'd2);
      guard = 0;
      while (addr0 != 5'd31 && guard < 400) begin cyc(); guard++; end
      chk("wrap_reach31", addr0, 5'd31);
      guard = 0;
      while (addr0 == 5'd31 && guard < 40) begin cyc(); guard++; end
      chk("wrap_to0", addr0, 5'd0);
      chk("wrap_to0_loop", addr1, 5'd0);
      cyc(); cyc();
      chk("wrap_note", note0, 20'd1000);
      do_stop();

      // Asynchronous reset in the middle of a note
      pulse_start(3'd1);
      cyc(); cyc(); cyc();
      chk_en = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst0", {note0, addr0, song0, play0, done0}, 32'd0);
      chk("async_rst1", {note1, addr1, song1, play1, done1}, 32'd0);
      cyc();
      rst = 1'b0;
      cyc();
      chk_en = 1'b1;

      // Randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         start    = ($urandom_range(0, 39) == 0);
         stop     = ($urandom_range(0, 149) == 0);
         song_sel = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 19) == 0) pause = ~pause;
         cyc();
      end
      start = 1'b0; stop = 1'b0; pause = 1'b0;
      cyc(); cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
